// File: rtl/tri_bbox_scanner.sv
// Bounding-box rasterizer front end: fetches triangles from the decoder and
// streams every on-screen pixel of each triangle's clipped bounding box in raster order.
module tri_bbox_scanner #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_ready,
  input  logic        frame_ready,
  input  logic [15:0] x1,
  input  logic [15:0] y1,
  input  logic [15:0] x2,
  input  logic [15:0] y2,
  input  logic [15:0] x3,
  input  logic [15:0] y3,
  input  logic [7:0]  TexNum,
  output logic        next_triangle,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [7:0]  pix_tex,
  output logic        pix_last,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned CW = 16;
  localparam int unsigned TW = 8;
  localparam logic [CW-1:0] XLIM = CW'(SCREEN_W - 1);
  localparam logic [CW-1:0] YLIM = CW'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAPTURE,
    S_SETUP,
    S_SCAN,
    S_FRAME
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0] r_vx1, r_vy1, r_vx2, r_vy2, r_vx3, r_vy3;
  logic [TW-1:0] r_tex;
  logic [CW-1:0] r_xmin, r_xmaxc, r_ymaxc;
  logic [CW-1:0] r_cx, r_cy;
  logic          r_last;
  logic          r_next_triangle, r_pix_valid, r_frame_done, r_busy;

  logic [CW-1:0] w_xmin, w_xmax, w_ymin, w_ymax, w_xmaxc, w_ymaxc;
  logic          w_offscreen;
  logic          w_accept, w_row_end, w_last_next;
  logic [CW-1:0] w_cx_next, w_cy_next;

  function automatic logic [CW-1:0] min3(input logic [CW-1:0] a,
                                         input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [CW-1:0] max3(input logic [CW-1:0] a,
                                         input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Bounding box of the captured triangle, upper edges clipped to the screen
  always_comb begin
    w_xmin      = min3(r_vx1, r_vx2, r_vx3);
    w_xmax      = max3(r_vx1, r_vx2, r_vx3);
    w_ymin      = min3(r_vy1, r_vy2, r_vy3);
    w_ymax      = max3(r_vy1, r_vy2, r_vy3);
    w_xmaxc     = (w_xmax > XLIM) ? XLIM : w_xmax;
    w_ymaxc     = (w_ymax > YLIM) ? YLIM : w_ymax;
    w_offscreen = (w_xmin > w_xmaxc) || (w_ymin > w_ymaxc);
  end

  // Raster step to the following pixel
  always_comb begin
    w_accept    = r_pix_valid && pix_ready;
    w_row_end   = (r_cx == r_xmaxc);
    w_cx_next   = w_row_end ? r_xmin : r_cx + CW'(1);
    w_cy_next   = w_row_end ? r_cy + CW'(1) : r_cy;
    w_last_next = (w_cx_next == r_xmaxc) && (w_cy_next == r_ymaxc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    w_state_next = S_REQ;
      S_REQ:     w_state_next = S_WAIT;
      S_WAIT: begin
        if (data_ready)       w_state_next = S_CAPTURE;
        else if (frame_ready) w_state_next = S_FRAME;
      end
      S_CAPTURE: w_state_next = S_SETUP;
      S_SETUP:   w_state_next = w_offscreen ? S_REQ : S_SCAN;
      S_SCAN:    if (w_accept && r_last) w_state_next = S_REQ;
      S_FRAME:   w_state_next = S_REQ;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_next_triangle <= 1'b0;
      r_pix_valid     <= 1'b0;
      r_frame_done    <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_next_triangle <= (w_state_next == S_REQ);
      r_pix_valid     <= (w_state_next == S_SCAN);
      r_frame_done    <= (w_state_next == S_FRAME);
      r_busy          <= (w_state_next == S_CAPTURE) || (w_state_next == S_SETUP) ||
                         (w_state_next == S_SCAN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vx1   <= '0;
      r_vy1   <= '0;
      r_vx2   <= '0;
      r_vy2   <= '0;
      r_vx3   <= '0;
      r_vy3   <= '0;
      r_tex   <= '0;
      r_xmin  <= '0;
      r_xmaxc <= '0;
      r_ymaxc <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_last  <= 1'b0;
    end else begin
      if (r_state == S_CAPTURE) begin
        r_vx1 <= x1;
        r_vy1 <= y1;
        r_vx2 <= x2;
        r_vy2 <= y2;
        r_vx3 <= x3;
        r_vy3 <= y3;
        r_tex <= TexNum;
      end
      if ((r_state == S_SETUP) && !w_offscreen) begin
        r_xmin  <= w_xmin;
        r_xmaxc <= w_xmaxc;
        r_ymaxc <= w_ymaxc;
        r_cx    <= w_xmin;
        r_cy    <= w_ymin;
        r_last  <= (w_xmin == w_xmaxc) && (w_ymin == w_ymaxc);
      end
      // Counters move only on accept, so a stalled pixel holds stable
      if ((r_state == S_SCAN) && w_accept) begin
        if (r_last) begin
          r_last <= 1'b0;
        end else begin
          r_cx   <= w_cx_next;
          r_cy   <= w_cy_next;
          r_last <= w_last_next;
        end
      end
    end
  end

  assign next_triangle = r_next_triangle;
  assign pix_valid     = r_pix_valid;
  assign pix_x         = r_cx;
  assign pix_y         = r_cy;
  assign pix_tex       = r_tex;
  assign pix_last      = r_last;
  assign frame_done    = r_frame_done;
  assign busy          = r_busy;

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Directed bench for tri_bbox_scanner: table of triangles with hand-computed
// clipped bounding boxes, plus hand-written frame, priority and reset sequences.
module tb_tri_bbox_scanner;

  logic        clk;
  logic        reset;
  logic        data_ready;
  logic        frame_ready;
  logic [15:0] x1, y1, x2, y2, x3, y3;
  logic [7:0]  TexNum;
  logic        next_triangle;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_x, pix_y;
  logic [7:0]  pix_tex;
  logic        pix_last;
  logic        frame_done;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] x1, y1, x2, y2, x3, y3;
    logic [7:0]  tex;
    int          exmin, exmax, eymin, eymax;
    bit          off;
    int          stall_at, stall_len, frame_at, abort_at;
  } vec_t;

  vec_t vecs[7];

  tri_bbox_scanner #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk(clk), .reset(reset), .data_ready(data_ready), .frame_ready(frame_ready),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3), .TexNum(TexNum),
    .next_triangle(next_triangle), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_tex(pix_tex), .pix_last(pix_last),
    .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_next_triangle"}, 32'(next_triangle), 32'd0);
    chk({tag, "_pix_valid"},     32'(pix_valid),     32'd0);
    chk({tag, "_pix_x"},         32'(pix_x),         32'd0);
    chk({tag, "_pix_y"},         32'(pix_y),         32'd0);
    chk({tag, "_pix_tex"},       32'(pix_tex),       32'd0);
    chk({tag, "_pix_last"},      32'(pix_last),      32'd0);
    chk({tag, "_frame_done"},    32'(frame_done),    32'd0);
    chk({tag, "_busy"},          32'(busy),          32'd0);
  endtask

  task automatic wait_next_tri();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (next_triangle) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_next_triangle", 32'(found), 32'd1);
  endtask

  // One decoder transaction and the full pixel walk it should produce
  task automatic run_tri(input vec_t v);
    int w, n, ex, ey, el;
    wait_next_tri();
    tick();
    chk("next_triangle_one_cycle", 32'(next_triangle), 32'd0);
    x1 = v.x1; y1 = v.y1; x2 = v.x2; y2 = v.y2; x3 = v.x3; y3 = v.y3;
    TexNum = v.tex;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("lat_capture_valid", 32'(pix_valid), 32'd0);
    chk("lat_capture_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_setup_valid", 32'(pix_valid), 32'd0);
    tick();
    if (v.off) begin
      chk("offscreen_valid", 32'(pix_valid), 32'd0);
      chk("offscreen_next_triangle", 32'(next_triangle), 32'd1);
      return;
    end
    w = v.exmax - v.exmin + 1;
    n = w * (v.eymax - v.eymin + 1);
    for (int idx = 0; idx < n; idx++) begin
      ex = v.exmin + (idx % w);
      ey = v.eymin + (idx / w);
      el = ((ex == v.exmax) && (ey == v.eymax)) ? 1 : 0;
      chk("pix_valid", 32'(pix_valid), 32'd1);
      chk("pix_x", 32'(pix_x), 32'(ex));
      chk("pix_y", 32'(pix_y), 32'(ey));
      chk("pix_tex", 32'(pix_tex), 32'(v.tex));
      chk("pix_last", 32'(pix_last), 32'(el));
      chk("no_frame_done_in_scan", 32'(frame_done), 32'd0);
      if (idx == v.abort_at) begin
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("idle_after_reset_nt", 32'(next_triangle), 32'd0);
        tick();
        chk("req_after_idle_nt", 32'(next_triangle), 32'd1);
        return;
      end
      if (idx == v.frame_at) frame_ready = 1'b1;
      if (idx == v.stall_at) begin
        pix_ready = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          tick();
          frame_ready = 1'b0;
          chk("stall_valid", 32'(pix_valid), 32'd1);
          chk("stall_x", 32'(pix_x), 32'(ex));
          chk("stall_y", 32'(pix_y), 32'(ey));
          chk("stall_last", 32'(pix_last), 32'(el));
        end
        pix_ready = 1'b1;
      end
      tick();
      frame_ready = 1'b0;
    end
    chk("end_next_triangle", 32'(next_triangle), 32'd1);
    chk("end_valid_low", 32'(pix_valid), 32'd0);
    chk("end_frame_done", 32'(frame_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    //          x1   y1   x2   y2   x3   y3   tex    xmin xmax ymin ymax off stall len frm abort
    vecs[0] = '{16'd2,   16'd3,   16'd5,   16'd1,   16'd4,   16'd4,   8'd7,
                2, 5, 1, 4, 1'b0, -1, 0, 2, -1};
    vecs[1] = '{16'd2,   16'd3,   16'd5,   16'd1,   16'd4,   16'd4,   8'd7,
                2, 5, 1, 4, 1'b0, 5, 5, -1, -1};
    vecs[2] = '{16'd630, 16'd470, 16'd700, 16'd475, 16'd635, 16'd500, 8'd3,
                630, 639, 470, 479, 1'b0, -1, 0, -1, -1};
    vecs[3] = '{16'd700, 16'd10,  16'd800, 16'd20,  16'd650, 16'd30,  8'd9,
                0, 0, 0, 0, 1'b1, -1, 0, -1, -1};
    vecs[4] = '{16'd100, 16'd5,   16'd103, 16'd5,   16'd101, 16'd5,   8'hA5,
                100, 103, 5, 5, 1'b0, 0, 2, -1, -1};
    vecs[5] = '{16'd2,   16'd3,   16'd5,   16'd1,   16'd4,   16'd4,   8'd7,
                2, 5, 1, 4, 1'b0, -1, 0, -1, 3};
    vecs[6] = '{16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   16'd0,   8'h11,
                0, 0, 0, 0, 1'b0, -1, 0, -1, -1};

    reset = 1'b1;
    data_ready = 1'b0;
    frame_ready = 1'b0;
    pix_ready = 1'b1;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; x3 = '0; y3 = '0;
    TexNum = '0;
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("idle_nt", 32'(next_triangle), 32'd0);

    for (int k = 0; k < 7; k++) run_tri(vecs[k]);

    // Frame opcode consumed in WAIT
    wait_next_tri();
    tick();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("frame_nt_low", 32'(next_triangle), 32'd0);
    chk("frame_busy_low", 32'(busy), 32'd0);
    tick();
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    chk("frame_then_req", 32'(next_triangle), 32'd1);

    // data_ready and frame_ready together: triangle wins, frame dropped
    tick();
    x1 = 16'd20; y1 = 16'd30; x2 = 16'd20; y2 = 16'd30; x3 = 16'd20; y3 = 16'd30;
    TexNum = 8'h42;
    data_ready = 1'b1;
    frame_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    frame_ready = 1'b0;
    chk("prio_busy", 32'(busy), 32'd1);
    chk("prio_no_frame_done", 32'(frame_done), 32'd0);
    tick();
    tick();
    chk("prio_valid", 32'(pix_valid), 32'd1);
    chk("prio_x", 32'(pix_x), 32'd20);
    chk("prio_y", 32'(pix_y), 32'd30);
    chk("prio_tex", 32'(pix_tex), 32'h42);
    chk("prio_last", 32'(pix_last), 32'd1);
    tick();
    chk("prio_end_nt", 32'(next_triangle), 32'd1);
    chk("prio_end_valid", 32'(pix_valid), 32'd0);
    chk("prio_end_frame_done", 32'(frame_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
